// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ready handshake and
// presents the fetched instruction (plus op/func fields) to the control unit.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic [5:0]  op,
  output logic [5:0]  func
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] skid;
  logic [31:0] skid_pc;
  logic        kill;
  logic [31:0] target;

  assign target = redirect_pc & ~32'h3;
  assign op     = inst[31:26];
  assign func   = inst[5:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      imem_addr  <= RESET_PC;
      imem_req   <= 1'b0;
      inst       <= 32'h0;
      inst_pc    <= 32'h0;
      inst_valid <= 1'b0;
      skid       <= 32'h0;
      skid_pc    <= 32'h0;
      kill       <= 1'b0;
    end else if (redirect) begin
      inst       <= 32'h0;
      inst_valid <= 1'b0;
      skid       <= 32'h0;
      skid_pc    <= 32'h0;
      pc         <= target;
      // An outstanding read cannot be withdrawn, so its word is marked for discard instead.
      if (state == REQ && !imem_ready) begin
        kill <= 1'b1;
      end else begin
        kill      <= 1'b0;
        imem_addr <= target;
        imem_req  <= 1'b1;
        state     <= REQ;
      end
    end else begin
      case (state)
        IDLE: begin
          state     <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        REQ: begin
          if (imem_ready) begin
            if (kill) begin
              kill      <= 1'b0;
              imem_addr <= pc;
            end else if (!inst_valid || !stall) begin
              inst       <= imem_rdata;
              inst_pc    <= imem_addr;
              inst_valid <= 1'b1;
              pc         <= pc + 32'd4;
              imem_addr  <= pc + 32'd4;
            end else begin
              skid     <= imem_rdata;
              skid_pc  <= imem_addr;
              pc       <= pc + 32'd4;
              imem_req <= 1'b0;
              state    <= HOLD;
            end
          end else if (!stall) begin
            inst       <= 32'h0;
            inst_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            inst       <= skid;
            inst_pc    <= skid_pc;
            inst_valid <= 1'b1;
            skid       <= 32'h0;
            skid_pc    <= 32'h0;
            imem_addr  <= pc;
            imem_req   <= 1'b1;
            state      <= REQ;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: cycle vector table with a zero-wait memory, then wait-state
// sequences whose accepted instructions are checked in order against a scoreboard.
module tb_inst_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic [5:0]  op;
  logic [5:0]  func;

  int checks = 0;
  int errors = 0;
  int wait_cfg = 0;
  int wait_cnt = 0;
  bit sb_on = 1'b0;
  logic [31:0] sb_q[$];

  inst_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .op(op), .func(func)
  );

  always #5 clk = ~clk;

  // Memory answers after wait_cfg idle request cycles; data is the address plus a fixed tag.
  assign imem_ready = imem_req && (wait_cnt >= wait_cfg);
  assign imem_rdata = imem_ready ? (imem_addr + 32'h8C00_0000) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (!imem_req || imem_ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic s, input logic rd,
                                input logic [31:0] rp);
    @(posedge clk);
    #2;
    rst         = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rp;
  endtask

  // An instruction is accepted downstream whenever it is valid and not stalled.
  always @(negedge clk) begin
    if (sb_on && inst_valid && !stall) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected: got inst_pc %h, expected no instruction", inst_pc);
      end else begin
        logic [31:0] exp_pc;
        exp_pc = sb_q.pop_front();
        check_output("sb_inst_pc", inst_pc, exp_pc);
        check_output("sb_inst", inst, exp_pc + 32'h8C00_0000);
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_ipc;
    logic [31:0] exp_inst;
    logic        ipc_care;
  } vec_t;

  vec_t vecs[16];

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0,         1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0,         1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   32'h0,         1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,   32'h8C00_0000, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4,   32'h8C00_0004, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8,   32'h8C00_0008, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h8,   32'h8C00_0008, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'hC,   1'b1, 32'h8,   32'h8C00_0008, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC,   32'h8C00_000C, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h203, 1'b1, 32'h14,  1'b1, 32'h10,  32'h8C00_0010, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0,   32'h0,         1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200, 32'h8C00_0200, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h204, 1'b1, 32'h200, 32'h8C00_0200, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h204, 32'h8C00_0204, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h20C, 1'b1, 32'h208, 32'h8C00_0208, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   32'h0,         1'b1};

    // Each row holds the inputs driven in a cycle and the outputs seen in that same cycle.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
      @(negedge clk);
      check_output($sformatf("v%0d_req", i), imem_req, vecs[i].exp_req);
      check_output($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check_output($sformatf("v%0d_valid", i), inst_valid, vecs[i].exp_valid);
      check_output($sformatf("v%0d_inst", i), inst, vecs[i].exp_inst);
      check_output($sformatf("v%0d_op", i), op, vecs[i].exp_inst[31:26]);
      check_output($sformatf("v%0d_func", i), func, vecs[i].exp_inst[5:0]);
      if (vecs[i].ipc_care)
        check_output($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].exp_ipc);
    end

    // Three-cycle memory: each address is presented for three cycles, data on the third.
    wait_cfg = 2;
    sb_on    = 1'b1;
    sb_q.push_back(32'h0);
    sb_q.push_back(32'h4);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check_output("wait_req", imem_req, 1'b1);
      check_output("wait_addr", imem_addr, 32'h0);
      check_output("wait_valid", inst_valid, 1'b0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("wait_first_pc", inst_pc, 32'h0);
    check_output("wait_next_addr", imem_addr, 32'h4);
    idle_cycles(2);

    // Stall for four cycles while the word at 8 returns into the skid buffer.
    sb_q.push_back(32'h8);
    sb_q.push_back(32'hC);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check_output("stall_start_pc", inst_pc, 32'h4);
    check_output("stall_start_addr", imem_addr, 32'h8);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check_output("hold_req", imem_req, 1'b0);
    check_output("hold_inst", inst, 32'h8C00_0004);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("release_pc", inst_pc, 32'h4);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("skid_pc", inst_pc, 32'h8);
    check_output("resume_addr", imem_addr, 32'hC);
    check_output("resume_req", imem_req, 1'b1);
    idle_cycles(2);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("pre_redirect_addr", imem_addr, 32'h10);

    // Redirect to 0x103 while the read of 0x10 is outstanding.
    sb_q.push_back(32'h100);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    @(negedge clk);
    check_output("kill_pending_addr", imem_addr, 32'h10);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("kill_held_addr", imem_addr, 32'h10);
    check_output("kill_held_req", imem_req, 1'b1);
    check_output("kill_valid", inst_valid, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("redir_addr", imem_addr, 32'h100);
    check_output("redir_valid", inst_valid, 1'b0);
    idle_cycles(2);
    @(negedge clk);
    check_output("redir_wait_valid", inst_valid, 1'b0);

    // Redirect to the top word, then wrap to address 0.
    sb_q.push_back(32'hFFFF_FFFC);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    @(negedge clk);
    check_output("redir_target_pc", inst_pc, 32'h100);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("kill2_addr", imem_addr, 32'h104);
    idle_cycles(1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("top_addr", imem_addr, 32'hFFFF_FFFC);
    idle_cycles(2);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("top_inst_pc", inst_pc, 32'hFFFF_FFFC);
    check_output("wrap_addr", imem_addr, 32'h0);

    // Reset in the middle of a wait, then restart from RESET_PC.
    sb_q.push_back(32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("rst_mid_req_before", imem_req, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("rst_mid_req", imem_req, 1'b0);
    check_output("rst_mid_valid", inst_valid, 1'b0);
    check_output("rst_mid_addr", imem_addr, 32'h0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("restart_req", imem_req, 1'b1);
    check_output("restart_addr", imem_addr, 32'h0);
    idle_cycles(2);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("restart_inst_pc", inst_pc, 32'h0);
    check_output("restart_valid", inst_valid, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check_output("sb_drained", sb_q.size(), 32'd0);
    sb_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
